// File: rtl/alu_ctrl.sv
// Instruction sequencer for the 8-bit combinational ALU: decodes instruction bytes,
// feeds operands from ACC and a 4-entry register file, and writes results back.
// Optional zero flag (OUT_Z) is enabled by defining ALU_CTRL_ZFLAG_EN.
module alu_ctrl #(
  parameter int unsigned NREGS = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] IN_INSTR,
  input  logic       IN_VALID,
  output logic       OUT_READY,
  output logic [7:0] OUT_ALU_A,
  output logic [7:0] OUT_ALU_R,
  output logic [2:0] OUT_ALU_OP,
  input  logic [7:0] IN_ALU_RES,
  input  logic       IN_ALU_CY,
  output logic [7:0] OUT_ACC,
`ifdef ALU_CTRL_ZFLAG_EN
  output logic       OUT_CY,
  output logic       OUT_Z
`else
  output logic       OUT_CY
`endif
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpSt  = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StImm} state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       sub_q, sub_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] acc_q, acc_d;
  logic       cy_q, cy_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];
`ifdef ALU_CTRL_ZFLAG_EN
  logic       z_q, z_d;
`endif

  // Reserved instruction bits carry no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ^IN_INSTR[3:2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      op_q    <= '0;
      sub_q   <= 1'b0;
      sel_q   <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef ALU_CTRL_ZFLAG_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      regs_q  <= regs_d;
`ifdef ALU_CTRL_ZFLAG_EN
      z_q     <= z_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sub_d     = sub_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    cy_d      = cy_q;
    regs_d    = regs_q;
`ifdef ALU_CTRL_ZFLAG_EN
    z_d       = z_q;
`endif
    OUT_READY = 1'b0;
    unique case (state_q)
      StIdle: begin
        OUT_READY = 1'b1;
        if (IN_VALID) begin
          op_d    = IN_INSTR[7:5];
          sub_d   = IN_INSTR[4];
          sel_d   = IN_INSTR[1:0];
          state_d = (IN_INSTR[7:5] == OpSt && IN_INSTR[4]) ? StImm : StExec;
        end
      end
      StExec: begin
        if (op_q == OpSt) begin
          // LDI never reaches EXEC; guard keeps the store strictly to ST.
          if (!sub_q) regs_d[sel_q] = acc_q;
        end else begin
          acc_d = IN_ALU_RES;
          if (op_q == OpAdd || op_q == OpSub) cy_d = IN_ALU_CY;
`ifdef ALU_CTRL_ZFLAG_EN
          z_d = (IN_ALU_RES == 8'h00);
`endif
        end
        state_d = StIdle;
      end
      StImm: begin
        OUT_READY = 1'b1;
        if (IN_VALID) begin
          regs_d[sel_q] = IN_INSTR;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign OUT_ALU_A  = acc_q;
  assign OUT_ALU_R  = regs_q[sel_q];
  assign OUT_ALU_OP = op_q;
  assign OUT_ACC    = acc_q;
  assign OUT_CY     = cy_q;
`ifdef ALU_CTRL_ZFLAG_EN
  assign OUT_Z      = z_q;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: bench-side ALU, instruction-level reference model,
// per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_alu_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IN_INSTR;
  logic       IN_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_ALU_A, OUT_ALU_R;
  logic [2:0] OUT_ALU_OP;
  logic [7:0] IN_ALU_RES;
  logic       IN_ALU_CY;
  logic [7:0] OUT_ACC;
  logic       OUT_CY;
`ifdef ALU_CTRL_ZFLAG_EN
  logic       OUT_Z;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  alu_ctrl #(.NREGS(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .IN_INSTR(IN_INSTR),
    .IN_VALID(IN_VALID),
    .OUT_READY(OUT_READY),
    .OUT_ALU_A(OUT_ALU_A),
    .OUT_ALU_R(OUT_ALU_R),
    .OUT_ALU_OP(OUT_ALU_OP),
    .IN_ALU_RES(IN_ALU_RES),
    .IN_ALU_CY(IN_ALU_CY),
    .OUT_ACC(OUT_ACC),
`ifdef ALU_CTRL_ZFLAG_EN
    .OUT_CY(OUT_CY),
    .OUT_Z(OUT_Z)
`else
    .OUT_CY(OUT_CY)
`endif
  );

  always #5 CLK = ~CLK;

  // ALU behaviour; carry for logic ops is arbitrary so a controller that wrongly
  // latches it gets caught.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] r);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, r};
      3'b001:  return {1'b0, a} - {1'b0, r};
      3'b010:  return {~a[0], a | r};
      3'b011:  return {~a[0], a & r};
      3'b100:  return {~a[0], a ^ r};
      3'b101:  return {~a[0], ~a};
      3'b110:  return {~a[0], r};
      default: return 9'h1AB;
    endcase
  endfunction

  always_comb {IN_ALU_CY, IN_ALU_RES} = alu_fn(OUT_ALU_OP, OUT_ALU_A, OUT_ALU_R);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: instruction-level state plus one pending ALU/ST instruction.
  logic [7:0] m_acc, m_pend;
  logic       m_cy, m_z, m_pend_v, m_imm_v;
  logic [1:0] m_imm_sel;
  logic [7:0] m_r [4];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_acc <= 8'h00; m_cy <= 1'b0; m_z <= 1'b0;
      m_pend_v <= 1'b0; m_imm_v <= 1'b0; m_pend <= 8'h00; m_imm_sel <= 2'd0;
      for (int i = 0; i < 4; i++) m_r[i] <= 8'h00;
    end else if (m_pend_v) begin
      m_pend_v <= 1'b0;
      if (m_pend[7:5] != 3'b111) begin
        m_acc <= alu_fn(m_pend[7:5], m_acc, m_r[m_pend[1:0]]);
        m_z   <= (alu_fn(m_pend[7:5], m_acc, m_r[m_pend[1:0]]) & 9'h0FF) == 9'h000;
        if (m_pend[7:5] <= 3'b001) m_cy <= alu_fn(m_pend[7:5], m_acc, m_r[m_pend[1:0]]) >> 8;
      end else begin
        m_r[m_pend[1:0]] <= m_acc;
      end
    end else if (IN_VALID) begin
      if (m_imm_v) begin
        m_r[m_imm_sel] <= IN_INSTR;
        m_imm_v <= 1'b0;
      end else if (IN_INSTR[7:4] == 4'hF) begin
        m_imm_v <= 1'b1;
        m_imm_sel <= IN_INSTR[1:0];
      end else begin
        m_pend_v <= 1'b1;
        m_pend <= IN_INSTR;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && chk_en) begin
      check("acc", OUT_ACC, m_acc);
      check("cy", OUT_CY, m_cy);
      check("ready", OUT_READY, !m_pend_v);
`ifdef ALU_CTRL_ZFLAG_EN
      check("z", OUT_Z, m_z);
`endif
      if (m_pend_v) begin
        check("alu_op", OUT_ALU_OP, m_pend[7:5]);
        check("alu_a", OUT_ALU_A, m_acc);
        check("alu_r", OUT_ALU_R, m_r[m_pend[1:0]]);
      end
    end
  end

  // All tasks enter and leave at posedge + 1.
  task automatic step();
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 1'b0;
    IN_INSTR = b;
    IN_VALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = OUT_READY;
      @(posedge CLK); #1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL send_timeout: byte %0h not accepted, expected accept within 20", b);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    #1;
    check("rst_acc", OUT_ACC, 8'h00);
    check("rst_cy", OUT_CY, 1'b0);
    check("rst_ready", OUT_READY, 1'b1);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; IN_INSTR = 8'h00;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;

    do_reset();

    // LDI R1=01, ADD R1; ready low exactly one cycle after accept
    send(8'hF1); send(8'h01);
    send(8'h01);
    check("add_ready_lo", OUT_READY, 1'b0);
    step();
    check("add_ready_hi", OUT_READY, 1'b1);
    check("add_acc", OUT_ACC, 8'h01);

    // LDI R2=05, SUB R2: 1-5 borrows
    send(8'hF2); send(8'h05);
    send(8'h22);
    check("sub_ready_lo", OUT_READY, 1'b0);
    step();
    check("sub_ready_hi", OUT_READY, 1'b1);
    check("sub_acc", OUT_ACC, 8'hFC);
    check("sub_cy", OUT_CY, 1'b1);

    // ADD wrap: FF + 01
    send(8'hF0); send(8'hFF); send(8'hC0);
    send(8'hF3); send(8'h01); send(8'h03); step();
    check("wrap_acc", OUT_ACC, 8'h00);
    check("wrap_cy", OUT_CY, 1'b1);
`ifdef ALU_CTRL_ZFLAG_EN
    check("wrap_z", OUT_Z, 1'b1);
`endif

    // Logic ops hold CY
    send(8'hF0); send(8'hAA); send(8'hC0);
    send(8'hF1); send(8'h55);
    send(8'h41); step();
    check("or_acc", OUT_ACC, 8'hFF);
    check("or_cy", OUT_CY, 1'b1);
    send(8'h61); step();
    check("and_acc", OUT_ACC, 8'h55);
    send(8'hA0); step();
    check("not_acc", OUT_ACC, 8'hAA);
    check("not_cy", OUT_CY, 1'b1);

    // ST R2, clear ACC, 5-cycle gap, LD R2
    send(8'hF0); send(8'h3C); send(8'hC0);
    send(8'hE2);
    send(8'hF0); send(8'h00); send(8'hC0);
    IN_INSTR = 8'h22;
    repeat (5) step();
    check("gap_acc", OUT_ACC, 8'h00);
    send(8'hC2); step();
    check("st_ld_acc", OUT_ACC, 8'h3C);

    // Reset mid-LDI: R1 must stay 0 and the next byte is an instruction
    send(8'hF1);
    do_reset();
    send(8'hF0); send(8'h07); send(8'hC0);
    send(8'hC1); step();
    check("mid_ldi_r1", OUT_ACC, 8'h00);

    // Reset mid-EXEC: no write-back
    send(8'hF0); send(8'h09); send(8'hC0);
    send(8'h00);
    do_reset();
    check("mid_exec_acc", OUT_ACC, 8'h00);

    // Random traffic checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) step();
      send(8'($urandom));
    end
    repeat (3) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
